// File: rtl/multi_maindec.sv
// -----------------------------------------------------------------------------
// multi_maindec
//   Main control FSM for the multicycle MIPS datapath. Each instruction is
//   stepped through fetch, decode, execute, memory and writeback states. The
//   block drives the datapath enables, the mux selects and the ALU-decoder op.
//
//   Optional build macro:
//     MULTI_MAINDEC_BNE_EN  adds the bne opcode (000101), the BNEEX state and
//                           the branch_ne output. Without it, bne is illegal.
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   reset_n     asynchronous active-low reset; write enables forced low
//   op          opcode instr[31:26] from the instruction register
//   mem_ready   memory access completes this cycle
//   pcwrite     unconditional PC load
//   branch      PC load if zero (ANDed with zero outside this block)
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   memwrite    memory write strobe
//   irwrite     instruction register load
//   regdst      register write address: 0 = rt, 1 = rd
//   memtoreg    register write data: 0 = ALUOut, 1 = Data
//   regwrite    register-file write enable
//   alusrca     ALU A: 0 = PC, 1 = register A
//   alusrcb     ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   pcsrc       PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//   aluop       00 = add, 01 = sub, 10 = funct-decoded
//   illegal_op  unsupported opcode seen in DECODE (one cycle)
//   branch_ne   PC load if not zero (only with MULTI_MAINDEC_BNE_EN)
// -----------------------------------------------------------------------------
module multi_maindec #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           branch,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           illegal_op
`ifdef MULTI_MAINDEC_BNE_EN
    ,
    output logic           branch_ne
`endif
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`ifdef MULTI_MAINDEC_BNE_EN
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MULTI_MAINDEC_BNE_EN
        ,
        BNEEX   = 4'd12
`endif
    } state_t;

    state_t state;
    state_t next_state;

    // NOTE: state register uses non-blocking assignment so every flop samples
    // the pre-edge value of next_state; blocking here would race other flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output and next_state gets a default before the case, so no
    // path through this block leaves a signal unassigned (no inferred latch).
    always_comb begin
        next_state = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
`ifdef MULTI_MAINDEC_BNE_EN
        branch_ne  = 1'b0;
`endif

        case (state)
            FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed
                // together with the IR load once memory has the word.
                alusrcb    = 2'b01;
                irwrite    = mem_ready;
                pcwrite    = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target PC + (SignImm<<2) is parked in ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
`ifdef MULTI_MAINDEC_BNE_EN
                    OP_BNE:       next_state = BNEEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                // The strobe is held for the whole wait, not pulsed.
                iord       = 1'b1;
                memwrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
`ifdef MULTI_MAINDEC_BNE_EN
            BNEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                branch_ne = 1'b1;
                pcsrc     = 2'b01;
            end
`endif
            default: begin
                // Unused encodings: all outputs stay 0, recover via FETCH.
                next_state = FETCH;
            end
        endcase

        // The state register already sits in FETCH during reset; this keeps
        // FETCH's mem_ready-driven loads from leaking out while reset is held.
        if (!reset_n) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            branch   = 1'b0;
`ifdef MULTI_MAINDEC_BNE_EN
            branch_ne = 1'b0;
`endif
        end
    end

endmodule
